param_stack: RTL and testbench

Parametrised LIFO stack for the multicycle datapath, the successor of the fixed 8-bit × 32-entry operand stack. Generalised in data width and depth. Adds:
- full/empty/count status;
- sticky overflow/underflow error flags;
- a defined push+pop "replace top" operation;
- a registered read port with a valid strobe.

It sits beside the register file and is driven by the controller FSM, one operation per cycle.

---
 rtl/param_stack.sv | 131 +++++++++++++
 tb/tb_param_stack.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_stack.sv
// -----------------------------------------------------------------------------
// param_stack - parametrised LIFO operand stack with registered read port.
//
// Parameters:
//   DATA_W  data width in bits (>= 1)
//   DEPTH   number of entries (>= 2, any value)
//   CNT_W   width of count, derived from DEPTH
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   din         data to push
//   push        push request
//   pop         pop request
//   tos         read top of stack without popping
//   err_clr     synchronous clear of the sticky error flags
//   dout        registered read data
//   dout_valid  one-cycle strobe, dout updated by a successful read
//   count       number of valid entries, 0..DEPTH
//   empty       count == 0
//   full        count == DEPTH
//   err_ovf     sticky: push while full without pop
//   err_udf     sticky: pop or tos while empty
// -----------------------------------------------------------------------------
module param_stack #(
   parameter int unsigned  DATA_W = 8,
   parameter int unsigned  DEPTH  = 32,
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              push,
   input  logic              pop,
   input  logic              tos,
   input  logic              err_clr,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full,
   output logic              err_ovf,
   output logic              err_udf
);

   localparam int unsigned      AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_dout;
   logic              r_dout_valid;
   logic              r_err_ovf;
   logic              r_err_udf;

   logic              w_empty;
   logic              w_full;
   logic [AW-1:0]     w_rd_idx;
   logic [AW-1:0]     w_wr_idx;
   logic              w_wr_en;
   logic              w_rd_ok;
   logic              w_ovf_evt;
   logic              w_udf_evt;
   logic [CNT_W-1:0]  w_count_nxt;

   always_comb begin
      w_empty   = (r_count == '0);
      w_full    = (r_count == FULL_CNT);
      // Top-of-stack index; only consumed when the stack is not empty.
      w_rd_idx  = AW'(r_count - 1'b1);
      // push+pop on a non-empty stack overwrites the top (replace);
      // on an empty stack the push lands in slot 0 like a plain push.
      w_wr_en   = push && (pop || !w_full);
      w_wr_idx  = (pop && !w_empty) ? w_rd_idx : AW'(r_count);
      w_rd_ok   = (pop || tos) && !w_empty;
      w_ovf_evt = push && !pop && w_full;
      w_udf_evt = (pop || tos) && w_empty;

      w_count_nxt = r_count;
      if (push && !pop && !w_full) begin
         w_count_nxt = r_count + 1'b1;
      end else if (push && pop && w_empty) begin
         w_count_nxt = r_count + 1'b1;
      end else if (pop && !push && !w_empty) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_idx] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count      <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_err_ovf    <= 1'b0;
         r_err_udf    <= 1'b0;
      end else begin
         r_count      <= w_count_nxt;
         r_dout_valid <= w_rd_ok;
         if (w_rd_ok) begin
            r_dout <= r_mem[w_rd_idx];
         end
         // A new error event takes priority over a same-cycle clear.
         if (w_ovf_evt) begin
            r_err_ovf <= 1'b1;
         end else if (err_clr) begin
            r_err_ovf <= 1'b0;
         end
         if (w_udf_evt) begin
            r_err_udf <= 1'b1;
         end else if (err_clr) begin
            r_err_udf <= 1'b0;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign count      = r_count;
   assign empty      = w_empty;
   assign full       = w_full;
   assign err_ovf    = r_err_ovf;
   assign err_udf    = r_err_udf;

endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] din;
   logic              push;
   logic              pop;
   logic              tos;
   logic              err_clr;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              full;
   logic              err_ovf;
   logic              err_udf;

   param_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .din(din), .push(push), .pop(pop), .tos(tos),
      .err_clr(err_clr), .dout(dout), .dout_valid(dout_valid), .count(count),
      .empty(empty), .full(full), .err_ovf(err_ovf), .err_udf(err_udf)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: a queue whose back is the top of stack.
   logic [DATA_W-1:0] m_q[$];
   logic [DATA_W-1:0] m_dout;
   bit                m_dv, m_ovf, m_udf;

   typedef struct {
      bit          pu, po, to, cl;
      logic [7:0]  d;
      int          cnt;
      logic [7:0]  dout;
      bit          dv, ovf, udf;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_dout = '0;
      m_dv   = 0;
      m_ovf  = 0;
      m_udf  = 0;
   endtask

   task automatic model_step(input bit pu, po, to, cl, input logic [7:0] d);
      bit emp, ful, ovf_e, udf_e;
      emp   = (m_q.size() == 0);
      ful   = (m_q.size() == DEPTH);
      ovf_e = 0;
      udf_e = 0;
      m_dv  = 0;
      if (po || to) begin
         if (!emp) begin
            m_dout = m_q[m_q.size()-1];
            m_dv   = 1;
         end else begin
            udf_e = 1;
         end
      end
      if (pu && po) begin
         if (!emp) m_q[m_q.size()-1] = d;
         else      m_q.push_back(d);
      end else if (pu) begin
         if (!ful) m_q.push_back(d);
         else      ovf_e = 1;
      end else if (po && !emp) begin
         void'(m_q.pop_back());
      end
      m_ovf = ovf_e ? 1'b1 : (cl ? 1'b0 : m_ovf);
      m_udf = udf_e ? 1'b1 : (cl ? 1'b0 : m_udf);
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(m_q.size()));
      chk({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
      chk({tag, ".full"},  32'(full),  32'(m_q.size() == DEPTH));
      chk({tag, ".dout"},  32'(dout),  32'(m_dout));
      chk({tag, ".dv"},    32'(dout_valid), 32'(m_dv));
      chk({tag, ".ovf"},   32'(err_ovf), 32'(m_ovf));
      chk({tag, ".udf"},   32'(err_udf), 32'(m_udf));
   endtask

   // Drive one operation, clock it, advance the model and compare.
   task automatic step(input string tag, input bit pu, po, to, cl, input logic [7:0] d);
      push = pu; pop = po; tos = to; err_clr = cl; din = d;
      @(posedge clk);
      #1;
      model_step(pu, po, to, cl, d);
      check_model(tag);
      push = 0; pop = 0; tos = 0; err_clr = 0;
   endtask

   vec_t vecs[$];

   task automatic addv(input bit pu, po, to, cl, input logic [7:0] d, input int cnt,
                       input logic [7:0] dt, input bit dv, ovf, udf);
      vec_t v;
      v.pu = pu; v.po = po; v.to = to; v.cl = cl; v.d = d;
      v.cnt = cnt; v.dout = dt; v.dv = dv; v.ovf = ovf; v.udf = udf;
      vecs.push_back(v);
   endtask

   initial begin
      clk = 0; rst = 0; din = '0; push = 0; pop = 0; tos = 0; err_clr = 0;

      // Expected values written directly from the stack rules (DEPTH = 4).
      //    pu po to cl  din   cnt dout  dv ovf udf
      // fill / overflow / drain
      addv(1, 0, 0, 0, 8'h11, 1, 8'h00, 0, 0, 0);
      addv(1, 0, 0, 0, 8'h22, 2, 8'h00, 0, 0, 0);
      addv(1, 0, 0, 0, 8'h33, 3, 8'h00, 0, 0, 0);
      addv(1, 0, 0, 0, 8'h44, 4, 8'h00, 0, 0, 0);
      addv(1, 0, 0, 0, 8'h55, 4, 8'h00, 0, 1, 0);
      addv(0, 1, 0, 0, 8'h00, 3, 8'h44, 1, 1, 0);
      addv(0, 1, 0, 0, 8'h00, 2, 8'h33, 1, 1, 0);
      addv(0, 1, 0, 0, 8'h00, 1, 8'h22, 1, 1, 0);
      addv(0, 1, 0, 0, 8'h00, 0, 8'h11, 1, 1, 0);
      addv(0, 0, 0, 0, 8'h00, 0, 8'h11, 0, 1, 0);
      // error clear alone
      addv(0, 0, 0, 1, 8'h00, 0, 8'h11, 0, 0, 0);
      // replace at full
      addv(1, 0, 0, 0, 8'h01, 1, 8'h11, 0, 0, 0);
      addv(1, 0, 0, 0, 8'h02, 2, 8'h11, 0, 0, 0);
      addv(1, 0, 0, 0, 8'h03, 3, 8'h11, 0, 0, 0);
      addv(1, 0, 0, 0, 8'h04, 4, 8'h11, 0, 0, 0);
      addv(1, 1, 0, 0, 8'hAA, 4, 8'h04, 1, 0, 0);
      addv(0, 1, 0, 0, 8'h00, 3, 8'hAA, 1, 0, 0);
      addv(0, 1, 0, 0, 8'h00, 2, 8'h03, 1, 0, 0);
      addv(0, 1, 0, 0, 8'h00, 1, 8'h02, 1, 0, 0);
      addv(0, 1, 0, 0, 8'h00, 0, 8'h01, 1, 0, 0);
      // push+pop on empty
      addv(1, 1, 0, 0, 8'h5C, 1, 8'h01, 0, 0, 1);
      addv(0, 0, 1, 0, 8'h00, 1, 8'h5C, 1, 0, 1);
      addv(0, 0, 0, 1, 8'h00, 1, 8'h5C, 0, 0, 0);
      // tos semantics
      addv(0, 1, 0, 0, 8'h00, 0, 8'h5C, 1, 0, 0);
      addv(1, 0, 0, 0, 8'h7E, 1, 8'h5C, 0, 0, 0);
      addv(1, 0, 1, 0, 8'h3D, 2, 8'h7E, 1, 0, 0);
      addv(0, 1, 0, 0, 8'h00, 1, 8'h3D, 1, 0, 0);
      addv(0, 1, 0, 0, 8'h00, 0, 8'h7E, 1, 0, 0);
      // clear coinciding with a new underflow: the event wins
      addv(0, 1, 0, 1, 8'h00, 0, 8'h7E, 0, 0, 1);
      addv(0, 0, 0, 1, 8'h00, 0, 8'h7E, 0, 0, 0);

      // Asynchronous reset at start-up.
      #2 rst = 1;
      #2;
      model_reset();
      check_model("por");
      @(posedge clk);
      #1 rst = 0;

      for (int i = 0; i < vecs.size(); i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         step(t, vecs[i].pu, vecs[i].po, vecs[i].to, vecs[i].cl, vecs[i].d);
         chk({t, ".tcount"}, 32'(count),      32'(vecs[i].cnt));
         chk({t, ".tdout"},  32'(dout),       32'(vecs[i].dout));
         chk({t, ".tdv"},    32'(dout_valid), 32'(vecs[i].dv));
         chk({t, ".tovf"},   32'(err_ovf),    32'(vecs[i].ovf));
         chk({t, ".tudf"},   32'(err_udf),    32'(vecs[i].udf));
      end

      // Reset mid-operation: content and pending read result are discarded.
      step("rs1", 1, 0, 0, 0, 8'hA1);
      step("rs2", 1, 0, 0, 0, 8'hA2);
      step("rs3", 1, 0, 0, 0, 8'hA3);
      step("rs4", 0, 0, 1, 0, 8'h00);
      chk("rs4.dout_a3", 32'(dout), 32'h0000_00A3);
      push = 1; din = 8'hFF;
      #3 rst = 1;
      #1;
      model_reset();
      check_model("rst_async");
      @(posedge clk);
      #1;
      check_model("rst_held");
      rst = 0; push = 0;
      step("rs_pop", 0, 1, 0, 0, 8'h00);
      chk("rs_pop.count", 32'(count), 32'h0);
      chk("rs_pop.udf",   32'(err_udf), 32'h1);
      chk("rs_pop.dout",  32'(dout), 32'h0);
      chk("rs_pop.dv",    32'(dout_valid), 32'h0);

      // Full with tos+push: overflow flagged and the top is still read.
      step("tf0", 0, 0, 0, 1, 8'h00);
      for (int i = 0; i < DEPTH; i++) step("tf_fill", 1, 0, 0, 0, 8'(8'hC0 + i));
      step("tf_tp", 1, 0, 1, 0, 8'hEE);
      chk("tf_tp.dout", 32'(dout), 32'h0000_00C3);
      chk("tf_tp.ovf",  32'(err_ovf), 32'h1);
      chk("tf_tp.count", 32'(count), 32'(DEPTH));

      // Randomized traffic against the queue model.
      for (int i = 0; i < 2000; i++) begin
         step("rnd",
              $urandom_range(0, 99) < 50,
              $urandom_range(0, 99) < 40,
              $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < 5,
              8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
